pipemdu: RTL and testbench
==========================

# pipemdu

Iterative multiply/divide sequencer for the EXE stage of the pipelined CPU. It accepts MULT/MULTU/DIV/DIVU from the EXE stage and runs a 32-step shift-add multiply or restoring divide. It stalls the pipeline while busy and owns the HI/LO registers read by MFHI/MFLO and written by MTHI/MTLO. It drives no ALU or result-bus logic; HI/LO are forwarded onto the EXE result path by the existing mux.

## Interface
- No parameters; width fixed at 32.
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- estart  in  1  EXE holds a mult/div instruction; held high until it leaves EXE
- emdop  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with estart
- ea  in  32  rs operand (dividend / multiplicand; MTHI/MTLO data)
- eb  in  32  rt operand (divisor / multiplier)
- ewhi  in  1  MTHI in EXE: write ea to HI
- ewlo  in  1  MTLO in EXE: write ea to LO
- ecancel  in  1  flush (exception/redirect): abort any operation
- estall  out  1  freeze PC, IF/ID and ID/EXE registers
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, CALC, FIX. Reset: IDLE, hi=lo=0, step counter=0, internal operand and accumulator registers = 0.
- estall = (IDLE & estart & ~ecancel) | CALC. Combinational. Low in FIX.
- **IDLE accept.** In IDLE with estart and no ecancel:
  - Latch the op.
  - Latch |ea| and |eb| for signed ops, or raw values for unsigned ops.
  - Latch neg_q = ea[31]^eb[31] and neg_r = ea[31]; both forced to 0 for unsigned ops.
  - Clear the 64-bit accumulator and set counter=0. Go to CALC.
- **Divide by zero** (DIV/DIVU with eb=0): skip CALC and go straight to FIX. Result is LO=32'hFFFFFFFF, HI=ea unmodified, with no sign fix.
- **CALC multiply**, one step per cycle:
  - If multiplier bit0 is 1, add the multiplicand into the upper 33 bits.
  - Then shift {carry, acc, multiplier} right by 1.
- **CALC divide (restoring)**, one step per cycle:
  - Shift {rem, quo} left by 1 and trial-subtract the divisor from rem (33-bit).
  - If there is no borrow, keep the difference and set quo bit0=1.
  - Otherwise restore and set quo bit0=0.
- The counter increments each CALC cycle. After step 32 (counter==31 at the edge), go to FIX.
- **FIX**, written at the edge ending FIX:
  - Multiply: {HI,LO} = neg_q ? -product(64-bit) : product.
  - Divide: LO = neg_q ? -quo : quo; HI = neg_r ? -rem : rem.
  - Then return to IDLE.
- Signed 0x80000000 ÷ 0xFFFFFFFF: magnitudes 0x80000000/1 → LO=0x80000000, HI=0. No trap.
- MTHI/MTLO: in IDLE with estart low, ewhi loads hi<=ea and ewlo loads lo<=ea. Both may fire in the same cycle. They are ignored in CALC/FIX and when estart=1 (estart has priority).
- ecancel: in any state, return to IDLE next edge and leave hi/lo unchanged. In the same cycle it blocks accept and MT writes, and forces estall low.
- estart seen in FIX belongs to the next instruction. It is ignored until IDLE, then accepted normally.

## Timing
- Mult/div occupies EXE for 34 cycles: accept cycle (stall) + 32 CALC (stall) + FIX (no stall).
- The instruction advances at the edge ending FIX, and HI/LO update at that same edge. An MFHI/MFLO entering EXE the next cycle sees the new value; no forwarding is needed.
- Divide by zero takes 2 cycles: accept (stall) + FIX.
- MTHI/MTLO take effect at the end of their EXE cycle, with zero stall.
- Reset asserted mid-CALC: immediate IDLE, estall=0, hi=lo=0.
- No output depends combinationally on ea/eb.

## Test plan
- MULT ea=0xFFFFFFFD (−3), eb=5 → estall high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU ea=eb=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001, 34 cycles total.
- DIV ea=0xFFFFFFF9 (−7), eb=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU ea=100 by eb=0 → 2-cycle path; LO=0xFFFFFFFF, HI=100.
- MTHI 0x12345678, then DIV 0x80000000 ÷ 0xFFFFFFFF → HI=0x12345678 after MTHI, then LO=0x80000000, HI=0.
- Start MULTU 7×9, pulse ecancel at CALC step 10 → IDLE next cycle, estall=0, HI/LO unchanged. Repeat with resetn low at step 10 → HI=LO=0 asynchronously.

Source files
------------

// File: rtl/pipemdu.sv
`timescale 1ns/1ps
// pipemdu: iterative 32-step shift-add multiply / restoring divide; owns HI/LO.
// Latency: accept + 32 CALC + FIX = 34 cycles; divide by zero is accept + FIX.
// Backpressure: estall freezes the front end during accept and CALC, low in FIX.
module pipemdu (
    input  logic        clock,
    input  logic        resetn,
    input  logic        estart,
    input  logic [1:0]  emdop,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    input  logic        ewhi,
    input  logic        ewlo,
    input  logic        ecancel,
    output logic        estall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        op_div;     // latched op is DIV/DIVU
    logic        dz;         // latched divide-by-zero
    logic        neg_q;
    logic        neg_r;
    logic [31:0] opa;        // |ea|: multiplicand, or dividend shifting into quotient
    logic [31:0] opb;        // |eb|: multiplier shifting out, or divisor
    logic [63:0] acc;        // product; upper half doubles as divide remainder
    logic [4:0]  cnt;

    logic        accept;
    logic        in_signed;
    logic        in_dz;
    logic [31:0] ea_mag;
    logic [31:0] eb_mag;

    logic [32:0] mul_sum;
    logic [63:0] mul_acc;
    logic [31:0] mul_opb;

    logic [32:0] rem_sh;
    logic        no_borrow;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;

    logic [63:0] mul_res;
    logic [31:0] div_lo;
    logic [31:0] div_hi;

    // Input decode: accept qualification and operand magnitudes
    always_comb begin
        accept    = (state == IDLE) && estart && !ecancel;
        in_signed = !emdop[0];
        in_dz     = emdop[1] && (eb == 32'd0);
        ea_mag    = (in_signed && ea[31]) ? (32'd0 - ea) : ea;
        eb_mag    = (in_signed && eb[31]) ? (32'd0 - eb) : eb;
    end

    // One multiply step and one restoring-divide step, selected later by op_div
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (opb[0] ? {1'b0, opa} : 33'd0);
        mul_acc   = {mul_sum, acc[31:1]};
        mul_opb   = {acc[0], opb[31:1]};
        rem_sh    = {acc[63:32], opa[31]};
        no_borrow = (rem_sh >= {1'b0, opb});
        rem_nxt   = no_borrow ? (rem_sh[31:0] - opb) : rem_sh[31:0];
        quo_nxt   = {opa[30:0], no_borrow};
    end

    // Sign fix-up applied when results are committed in FIX
    always_comb begin
        mul_res = neg_q ? (64'd0 - acc) : acc;
        div_lo  = neg_q ? (32'd0 - opa) : opa;
        div_hi  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and stall; a flush always wins and never stalls
    always_comb begin
        state_nxt = state;
        estall    = 1'b0;
        if (ecancel) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (estart) begin
                        estall    = 1'b1;
                        state_nxt = in_dz ? FIX : CALC;
                    end
                end
                CALC: begin
                    estall = 1'b1;
                    if (cnt == 5'd31) state_nxt = FIX;
                end
                FIX:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operand latch on accept, then one iteration per CALC cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            op_div <= 1'b0;
            dz     <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opa    <= 32'd0;
            opb    <= 32'd0;
            acc    <= 64'd0;
            cnt    <= 5'd0;
        end else if (accept) begin
            op_div <= emdop[1];
            dz     <= in_dz;
            neg_q  <= in_signed && (ea[31] ^ eb[31]);
            neg_r  <= in_signed && ea[31];
            // a zero divisor returns the raw dividend in HI, so keep it unmodified
            opa    <= in_dz ? ea : ea_mag;
            opb    <= eb_mag;
            acc    <= 64'd0;
            cnt    <= 5'd0;
        end else if (state == CALC && !ecancel) begin
            cnt <= cnt + 5'd1;
            if (op_div) begin
                acc[63:32] <= rem_nxt;
                opa        <= quo_nxt;
            end else begin
                acc <= mul_acc;
                opb <= mul_opb;
            end
        end
    end

    // HI/LO: results commit at the edge ending FIX; MTHI/MTLO only when idle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (!ecancel) begin
            if (state == FIX) begin
                if (!op_div) begin
                    hi <= mul_res[63:32];
                    lo <= mul_res[31:0];
                end else if (dz) begin
                    hi <= opa;
                    lo <= 32'hFFFF_FFFF;
                end else begin
                    hi <= div_hi;
                    lo <= div_lo;
                end
            end else if (state == IDLE && !estart) begin
                if (ewhi) hi <= ea;
                if (ewlo) lo <= ea;
            end
        end
    end

endmodule

// File: tb/tb_pipemdu.sv
`timescale 1ns/1ps
// tb_pipemdu: table vectors, hand sequences for cancel/reset, random ops vs model.
// Latency: checks 33 stall cycles per op (1 for divide by zero) plus FIX.
// Backpressure: waits on estall with a bounded cycle budget.
module tb_pipemdu;

    logic        clock;
    logic        resetn;
    logic        estart;
    logic [1:0]  emdop;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ewhi;
    logic        ewlo;
    logic        ecancel;
    logic        estall;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    logic [31:0] mhi;
    logic [31:0] mlo;

    pipemdu dut (
        .clock  (clock),
        .resetn (resetn),
        .estart (estart),
        .emdop  (emdop),
        .ea     (ea),
        .eb     (eb),
        .ewhi   (ewhi),
        .ewlo   (ewlo),
        .ecancel(ecancel),
        .estall (estall),
        .hi     (hi),
        .lo     (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ecyc;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics computed with plain arithmetic
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [31:0]        ma;
        logic [31:0]        mb;
        logic [31:0]        q;
        logic [31:0]        r;
        logic               sg;
        sg = !op[1] ? !op[0] : !op[0];
        if (!op[1]) begin
            if (sg) begin
                sa = $signed({{32{a[31]}}, a});
                sb = $signed({{32{b[31]}}, b});
                return sa * sb;
            end
            return {32'd0, a} * {32'd0, b};
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        ma = (sg && a[31]) ? -a : a;
        mb = (sg && b[31]) ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (sg && (a[31] != b[31])) q = -q;
        if (sg && a[31]) r = -r;
        return {r, q};
    endfunction

    // Issue one mult/div, count stall cycles, return after HI/LO commit
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        @(negedge clock);
        estart = 1'b1;
        emdop  = op;
        ea     = a;
        eb     = b;
        cyc    = 0;
        #1;
        while (estall && cyc < 100) begin
            cyc++;
            @(negedge clock);
            #1;
        end
        if (cyc >= 100) begin
            total++;
            bad++;
            $display("FAIL stall_timeout: got %0d cycles want <100", cyc);
        end
        @(negedge clock);
        estart = 1'b0;
        #1;
    endtask

    task automatic do_mt(input logic whi, input logic wlo, input logic [31:0] d);
        @(negedge clock);
        ewhi = whi;
        ewlo = wlo;
        ea   = d;
        #1;
        check("mt_nostall", {63'd0, estall}, 64'd0);
        @(negedge clock);
        ewhi = 1'b0;
        ewlo = 1'b0;
        if (whi) mhi = d;
        if (wlo) mlo = d;
        #1;
        check("mt_hilo", {hi, lo}, {mhi, mlo});
    endtask

    initial begin
        int cyc;
        logic [63:0] exp;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vt[0] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 33};
        vt[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vt[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vt[3] = '{2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1};
        vt[4] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
        vt[5] = '{2'b11, 32'd1000,      32'd7,         32'd6,         32'd142,       33};

        resetn  = 1'b0;
        estart  = 1'b0;
        emdop   = 2'b00;
        ea      = 32'd0;
        eb      = 32'd0;
        ewhi    = 1'b0;
        ewlo    = 1'b0;
        ecancel = 1'b0;
        mhi     = 32'd0;
        mlo     = 32'd0;
        #12;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_stall", {63'd0, estall}, 64'd0);
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, cyc);
            check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vt[i].ecyc));
            check($sformatf("vec%0d_hilo", i), {hi, lo}, {vt[i].ehi, vt[i].elo});
            mhi = vt[i].ehi;
            mlo = vt[i].elo;
        end

        // MTHI, then most-negative / -1 which must not trap
        do_mt(1'b1, 1'b0, 32'h1234_5678);
        do_mt(1'b1, 1'b1, 32'hCAFE_F00D);
        do_mt(1'b1, 1'b0, 32'h1234_5678);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("ovf_cycles", 64'(cyc), 64'd33);
        check("ovf_hilo", {hi, lo}, {32'd0, 32'h8000_0000});
        mhi = hi === 32'd0 ? 32'd0 : 32'd0;
        mlo = 32'h8000_0000;

        // Cancel at CALC step 10; a concurrent MTHI must be blocked too
        @(negedge clock);
        estart = 1'b1;
        emdop  = 2'b01;
        ea     = 32'd7;
        eb     = 32'd9;
        repeat (10) @(negedge clock);
        #1;
        check("calc_stall", {63'd0, estall}, 64'd1);
        estart  = 1'b0;
        ecancel = 1'b1;
        ewhi    = 1'b1;
        ea      = 32'hDEAD_BEEF;
        #1;
        check("cancel_stall", {63'd0, estall}, 64'd0);
        @(negedge clock);
        ecancel = 1'b0;
        ewhi    = 1'b0;
        #1;
        check("cancel_idle_stall", {63'd0, estall}, 64'd0);
        check("cancel_hilo", {hi, lo}, {mhi, mlo});
        repeat (40) @(negedge clock);
        check("cancel_no_late_write", {hi, lo}, {mhi, mlo});
        do_mt(1'b0, 1'b1, 32'h0000_A5A5);

        // Reset asserted mid-CALC clears HI/LO without waiting for an edge
        @(negedge clock);
        estart = 1'b1;
        emdop  = 2'b01;
        ea     = 32'd7;
        eb     = 32'd9;
        repeat (10) @(negedge clock);
        #2;
        resetn = 1'b0;
        estart = 1'b0;
        #1;
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        check("rst_mid_stall", {63'd0, estall}, 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        mhi = 32'd0;
        mlo = 32'd0;
        do_op(2'b01, 32'd7, 32'd9, cyc);
        check("after_rst_hilo", {hi, lo}, 64'd63);
        mlo = 32'd63;

        // Random ops and MT writes against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                do_mt(1'($urandom_range(0, 1)), 1'b1, $urandom);
            end else begin
                rop = 2'($urandom_range(0, 3));
                ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
                if ($urandom_range(0, 7) == 0)      rb = 32'd0;
                else if ($urandom_range(0, 1) == 0) rb = 32'($urandom_range(1, 20));
                else                                rb = $urandom;
                if ($urandom_range(0, 5) == 0) rb = -rb;
                exp = model(rop, ra, rb);
                do_op(rop, ra, rb, cyc);
                check($sformatf("rnd%0d_cycles", i), 64'(cyc),
                      (rop[1] && rb == 32'd0) ? 64'd1 : 64'd33);
                check($sformatf("rnd%0d_op%0d_%h_%h", i, rop, ra, rb), {hi, lo}, exp);
                mhi = exp[63:32];
                mlo = exp[31:0];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
